// File: rtl/kinase_seq_pkg.sv
// Shared encodings, state type and valve patterns for the kinase-chip valve sequencer.
package kinase_seq_pkg;

   localparam int NUM_INLETS = 13;

   typedef enum logic [1:0] {
      OP_PUMP_A = 2'd0,
      OP_MIX_B  = 2'd1,
      OP_FLUSH  = 2'd2,
      OP_RSVD   = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_RUN    = 3'd2,
      ST_CLOSE  = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   // {a2,a1,a0}; a 1 keeps that peristaltic valve closed
   localparam logic [2:0] PUMP_A_PATTERN [0:5] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
   localparam logic [1:0] PUMP_B_PATTERN [0:1] = '{2'b10, 2'b01};

   localparam logic [NUM_INLETS-1:0] CTRL_A_CLOSED = '1;
   localparam logic [2:0]            PUMP_A_CLOSED = 3'b111;
   localparam logic [1:0]            PUMP_B_CLOSED = 2'b11;

endpackage

// File: rtl/peristaltic_phase_gen.sv
// Dwell timer and phase index for one pump; phase_idx is the index for the coming cycle
// so the caller can register its valve pattern in step with the phase change.
module peristaltic_phase_gen #(
   parameter int PHASE_CYCLES = 250,
   parameter int NPHASE       = 6,
   localparam int DW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1,
   localparam int IW = (NPHASE > 1) ? $clog2(NPHASE) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          clr,
   output logic [IW-1:0] phase_idx,
   output logic          stroke_tick
);

   localparam logic [DW-1:0] DWELL_LOAD = DW'(PHASE_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NPHASE - 1);

   logic [DW-1:0] dwell_q, dwell_d;
   logic [IW-1:0] idx_q, idx_d;

   always_comb begin
      dwell_d = dwell_q;
      idx_d   = idx_q;
      if (clr) begin
         dwell_d = DWELL_LOAD;
         idx_d   = '0;
      end else if (en) begin
         if (dwell_q == '0) begin
            dwell_d = DWELL_LOAD;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
         end else begin
            dwell_d = dwell_q - DW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dwell_q <= DWELL_LOAD;
         idx_q   <= '0;
      end else begin
         dwell_q <= dwell_d;
         idx_q   <= idx_d;
      end
   end

   assign phase_idx   = idx_d;
   assign stroke_tick = en && !clr && (dwell_q == '0) && (idx_q == IDX_LAST);

endmodule

// File: rtl/kinase_valve_sequencer.sv
// One-command-at-a-time sequencer driving the kinase chip's control and flush valve pads.
//  state  | meaning
//  IDLE   | ready for a command, all valves closed, mux cleared
//  SETTLE | inlet/mux set up, waiting for the fluid to settle
//  RUN    | pumping strokes or flushing
//  CLOSE  | all valves closed, mux held, waiting to settle again
//  DONE   | one-cycle completion pulse, err if rejected or aborted
module kinase_valve_sequencer
   import kinase_seq_pkg::*;
#(
   parameter int PHASE_CYCLES  = 250,
   parameter int SETTLE_CYCLES = 1000,
   parameter int CNT_W         = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [3:0]            cmd_chan,
   input  logic [3:0]            cmd_mux,
   input  logic [CNT_W-1:0]      cmd_count,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [NUM_INLETS-1:0] ctrl_a,
   output logic [3:0]            ctrl_s,
   output logic [2:0]            pump_a,
   output logic [1:0]            pump_b,
   output logic [NUM_INLETS-1:0] flush_ctrl_a,
   output logic [3:0]            flush_ctrl_s,
   output logic [2:0]            flush_pump_a,
   output logic [1:0]            flush_pump_b
);

   localparam int DW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int FW = CNT_W + DW;
   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

   state_e                  state_q, state_d;
   op_e                     op_q, op_d;
   logic [CNT_W-1:0]        strokes_q, strokes_d;
   logic [SW-1:0]           settle_q, settle_d;
   logic [FW-1:0]           flush_q, flush_d;
   logic                    failed_q, failed_d;
   logic                    cmd_ready_q, cmd_ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [NUM_INLETS-1:0]   ctrl_a_q, ctrl_a_d, fca_q, fca_d;
   logic [3:0]              ctrl_s_q, ctrl_s_d, fcs_q, fcs_d;
   logic [2:0]              pump_a_q, pump_a_d, fpa_q, fpa_d;
   logic [1:0]              pump_b_q, pump_b_d, fpb_q, fpb_d;
   logic                    go_close;
   logic                    gen_clr, en_a, en_b, tick_a, tick_b;
   logic [2:0]              idx_a;
   logic [0:0]              idx_b;
   logic [NUM_INLETS-1:0]   chan_oh;

   // Generators sit cleared outside RUN so every command starts on phase 0
   assign gen_clr = (state_q != ST_RUN);
   assign en_a    = (state_q == ST_RUN) && (op_q == OP_PUMP_A);
   assign en_b    = (state_q == ST_RUN) && (op_q == OP_MIX_B);
   assign chan_oh = NUM_INLETS'(1) << cmd_chan;

   peristaltic_phase_gen #(.PHASE_CYCLES(PHASE_CYCLES), .NPHASE(6)) u_gen_a (
      .clk(clk), .rst(rst), .en(en_a), .clr(gen_clr), .phase_idx(idx_a), .stroke_tick(tick_a)
   );

   peristaltic_phase_gen #(.PHASE_CYCLES(PHASE_CYCLES), .NPHASE(2)) u_gen_b (
      .clk(clk), .rst(rst), .en(en_b), .clr(gen_clr), .phase_idx(idx_b), .stroke_tick(tick_b)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      strokes_d = strokes_q;
      settle_d  = settle_q;
      flush_d   = flush_q;
      failed_d  = failed_q;
      ctrl_a_d  = ctrl_a_q;
      ctrl_s_d  = ctrl_s_q;
      pump_a_d  = pump_a_q;
      pump_b_d  = pump_b_q;
      fca_d     = fca_q;
      fcs_d     = fcs_q;
      fpa_d     = fpa_q;
      fpb_d     = fpb_q;
      go_close  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            ctrl_s_d = '0;
            failed_d = 1'b0;
            if (cmd_valid) begin
               if (cmd_op == OP_RSVD || cmd_chan >= 4'(NUM_INLETS)) begin
                  state_d  = ST_DONE;
                  failed_d = 1'b1;
               end else if (cmd_count == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d   = ST_SETTLE;
                  op_d      = op_e'(cmd_op);
                  strokes_d = cmd_count;
                  settle_d  = SETTLE_LOAD;
                  flush_d   = FW'(cmd_count) * FW'(PHASE_CYCLES) - FW'(1);
                  ctrl_s_d  = cmd_mux;
                  if (cmd_op == OP_FLUSH) fca_d = chan_oh;
                  else                    ctrl_a_d = ~chan_oh;
               end
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               go_close = 1'b1;
               failed_d = 1'b1;
            end else if (settle_q == '0) begin
               state_d = ST_RUN;
               case (op_q)
                  OP_PUMP_A: pump_a_d = PUMP_A_PATTERN[idx_a];
                  OP_MIX_B:  pump_b_d = PUMP_B_PATTERN[idx_b];
                  default: begin
                     fcs_d = '1;
                     fpa_d = '1;
                     fpb_d = '1;
                  end
               endcase
            end else begin
               settle_d = settle_q - SW'(1);
            end
         end
         ST_RUN: begin
            if (abort) begin
               go_close = 1'b1;
               failed_d = 1'b1;
            end else begin
               case (op_q)
                  OP_PUMP_A: begin
                     if (tick_a && strokes_q == CNT_W'(1)) go_close = 1'b1;
                     else begin
                        pump_a_d = PUMP_A_PATTERN[idx_a];
                        if (tick_a) strokes_d = strokes_q - CNT_W'(1);
                     end
                  end
                  OP_MIX_B: begin
                     if (tick_b && strokes_q == CNT_W'(1)) go_close = 1'b1;
                     else begin
                        pump_b_d = PUMP_B_PATTERN[idx_b];
                        if (tick_b) strokes_d = strokes_q - CNT_W'(1);
                     end
                  end
                  default: begin
                     if (flush_q == '0) go_close = 1'b1;
                     else               flush_d = flush_q - FW'(1);
                  end
               endcase
            end
         end
         ST_CLOSE: begin
            if (settle_q == '0) begin
               state_d  = ST_DONE;
               ctrl_s_d = '0;
            end else begin
               settle_d = settle_q - SW'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // ctrl_s is deliberately left alone here; it is released when CLOSE exits
      if (go_close) begin
         state_d  = ST_CLOSE;
         settle_d = SETTLE_LOAD;
         ctrl_a_d = CTRL_A_CLOSED;
         pump_a_d = PUMP_A_CLOSED;
         pump_b_d = PUMP_B_CLOSED;
         fca_d    = '0;
         fcs_d    = '0;
         fpa_d    = '0;
         fpb_d    = '0;
      end

      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
      err_d       = (state_d == ST_DONE) && failed_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_PUMP_A;
         strokes_q   <= '0;
         settle_q    <= '0;
         flush_q     <= '0;
         failed_q    <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         ctrl_a_q    <= CTRL_A_CLOSED;
         ctrl_s_q    <= '0;
         pump_a_q    <= PUMP_A_CLOSED;
         pump_b_q    <= PUMP_B_CLOSED;
         fca_q       <= '0;
         fcs_q       <= '0;
         fpa_q       <= '0;
         fpb_q       <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         strokes_q   <= strokes_d;
         settle_q    <= settle_d;
         flush_q     <= flush_d;
         failed_q    <= failed_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         ctrl_a_q    <= ctrl_a_d;
         ctrl_s_q    <= ctrl_s_d;
         pump_a_q    <= pump_a_d;
         pump_b_q    <= pump_b_d;
         fca_q       <= fca_d;
         fcs_q       <= fcs_d;
         fpa_q       <= fpa_d;
         fpb_q       <= fpb_d;
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
   assign ctrl_a       = ctrl_a_q;
   assign ctrl_s       = ctrl_s_q;
   assign pump_a       = pump_a_q;
   assign pump_b       = pump_b_q;
   assign flush_ctrl_a = fca_q;
   assign flush_ctrl_s = fcs_q;
   assign flush_pump_a = fpa_q;
   assign flush_pump_b = fpb_q;

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Scoreboard bench: each command pushes its expected per-cycle output frames, a negedge monitor pops and compares.
module tb_kinase_valve_sequencer;

   localparam int PC    = 2;
   localparam int SC    = 3;
   localparam int LIMIT = 2000;

   typedef struct packed {
      logic        ready, busy, done, err;
      logic [12:0] ca;
      logic [3:0]  cs;
      logic [2:0]  pa;
      logic [1:0]  pb;
      logic [12:0] fca;
      logic [3:0]  fcs;
      logic [2:0]  fpa;
      logic [1:0]  fpb;
   } frame_t;

   logic        clk = 1'b0;
   logic        rst, cmd_valid, cmd_ready, abort, busy, done, err;
   logic [1:0]  cmd_op, pump_b, flush_pump_b;
   logic [3:0]  cmd_chan, cmd_mux, ctrl_s, flush_ctrl_s;
   logic [15:0] cmd_count;
   logic [12:0] ctrl_a, flush_ctrl_a;
   logic [2:0]  pump_a, flush_pump_a;

   frame_t      obs, exp_f;
   frame_t      exp_q[$];
   string       cur_tag = "none";
   int          fidx = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [2:0]  pat_a [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
   logic [1:0]  pat_b [2] = '{2'b10, 2'b01};

   kinase_valve_sequencer #(.PHASE_CYCLES(PC), .SETTLE_CYCLES(SC), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_chan(cmd_chan), .cmd_mux(cmd_mux), .cmd_count(cmd_count), .abort(abort),
      .busy(busy), .done(done), .err(err), .ctrl_a(ctrl_a), .ctrl_s(ctrl_s),
      .pump_a(pump_a), .pump_b(pump_b), .flush_ctrl_a(flush_ctrl_a), .flush_ctrl_s(flush_ctrl_s),
      .flush_pump_a(flush_pump_a), .flush_pump_b(flush_pump_b)
   );

   always #5 clk = ~clk;

   assign obs = {cmd_ready, busy, done, err, ctrl_a, ctrl_s, pump_a, pump_b,
                 flush_ctrl_a, flush_ctrl_s, flush_pump_a, flush_pump_b};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic frame_t idle_f();
      frame_t f;
      f       = '0;
      f.ready = 1'b1;
      f.ca    = '1;
      f.pa    = '1;
      f.pb    = '1;
      return f;
   endfunction

   function automatic frame_t busy_f();
      frame_t f;
      f       = idle_f();
      f.ready = 1'b0;
      f.busy  = 1'b1;
      return f;
   endfunction

   // Expected frames from the cycle after accept until back in IDLE
   function automatic void push_cmd(input int op, input int chan, input int mux, input int count,
                                    input int abort_at, input int rst_at);
      frame_t base, f;
      int     run_len;
      bit     aborted;
      aborted = 1'b0;
      if (op == 3 || chan > 12 || count == 0) begin
         f      = busy_f();
         f.done = 1'b1;
         f.err  = (op == 3 || chan > 12);
         exp_q.push_back(f);
         exp_q.push_back(idle_f());
         return;
      end
      base    = busy_f();
      base.cs = 4'(mux);
      if (op == 2) base.fca[chan] = 1'b1;
      else         base.ca[chan]  = 1'b0;
      repeat (SC) exp_q.push_back(base);
      run_len = (op == 0) ? count * 6 * PC : (op == 1) ? count * 2 * PC : count * PC;
      for (int i = 0; i < run_len; i++) begin
         f = base;
         case (op)
            0: f.pa = pat_a[(i / PC) % 6];
            1: f.pb = pat_b[(i / PC) % 2];
            default: begin
               f.fcs = '1;
               f.fpa = '1;
               f.fpb = '1;
            end
         endcase
         exp_q.push_back(f);
         if (i == rst_at) begin
            exp_q.push_back(idle_f());
            exp_q.push_back(idle_f());
            return;
         end
         if (i == abort_at) begin
            aborted = 1'b1;
            break;
         end
      end
      f    = busy_f();
      f.cs = 4'(mux);
      repeat (SC) exp_q.push_back(f);
      f.cs   = '0;
      f.done = 1'b1;
      f.err  = aborted;
      exp_q.push_back(f);
      exp_q.push_back(idle_f());
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_f = exp_q.pop_front();
         chk($sformatf("%s[%0d]", cur_tag, fidx), {16'd0, obs}, {16'd0, exp_f});
         fidx++;
      end
   end

   // abort_at/rst_at index the RUN cycle after which the event takes effect; -1 disables
   task automatic run_cmd(input string tag, input int op, input int chan, input int mux,
                          input int count, input int abort_at, input int rst_at);
      int k;
      @(negedge clk);
      #1;
      cur_tag   = tag;
      cmd_op    = 2'(op);
      cmd_chan  = 4'(chan);
      cmd_mux   = 4'(mux);
      cmd_count = 16'(count);
      cmd_valid = 1'b1;
      push_cmd(op, chan, mux, count, abort_at, rst_at);
      k = 0;
      while (exp_q.size() > 0 && k < LIMIT) begin
         @(negedge clk);
         #1;
         if (k == 0) cmd_valid = 1'b0;
         if (abort_at >= 0 && k >= SC + abort_at) abort = 1'b1;
         rst = (rst_at >= 0 && k == SC + rst_at);
         k++;
      end
      abort = 1'b0;
      rst   = 1'b0;
      chk({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      int k;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      abort     = 1'b0;
      cmd_op    = '0;
      cmd_chan  = '0;
      cmd_mux   = '0;
      cmd_count = '0;
      repeat (2) @(negedge clk);
      chk("reset", {16'd0, obs}, {16'd0, idle_f()});
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_idle", {16'd0, obs}, {16'd0, idle_f()});

      run_cmd("pump_a_c2",   0, 4, 5, 2, -1, -1);
      run_cmd("flush_c3",    2, 12, 9, 3, -1, -1);
      run_cmd("rsvd_op",     3, 1, 6, 4, -1, -1);
      run_cmd("bad_chan",    0, 13, 6, 4, -1, -1);
      run_cmd("mix_abort",   1, 7, 10, 3, 5, -1);
      run_cmd("pump_rst",    0, 4, 5, 2, -1, 7);
      run_cmd("pump_a_c1",   0, 0, 15, 1, -1, -1);
      run_cmd("flush_c1",    2, 0, 1, 1, -1, -1);
      run_cmd("mix_c2",      1, 12, 2, 2, -1, -1);

      // valid held through a whole command, then a count=0 command rides the same valid
      @(negedge clk);
      #1;
      cur_tag   = "hold_valid";
      cmd_op    = 2'd1;
      cmd_chan  = 4'd2;
      cmd_mux   = 4'd3;
      cmd_count = 16'd1;
      cmd_valid = 1'b1;
      push_cmd(1, 2, 3, 1, -1, -1);
      push_cmd(1, 2, 3, 0, -1, -1);
      k = 0;
      while (exp_q.size() > 0 && k < LIMIT) begin
         @(negedge clk);
         #1;
         if (k == 10) cmd_count = 16'd0;
         if (k == 12) cmd_valid = 1'b0;
         k++;
      end
      cmd_valid = 1'b0;
      chk("hold_valid_drain", 64'(exp_q.size()), 64'd0);
      exp_q.delete();

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
